// File: rtl/perf_counter_dump_controller_pkg.sv
// Shared types and constants for the performance-counter dump path.
// Beat-count helpers let the top derive its serializer sizing from its own parameters.
package perf_counter_dump_controller_pkg;

  typedef enum logic [1:0] {
    PERF_DUMP_IDLE,
    PERF_DUMP_HEADER,
    PERF_DUMP_DATA
  } perf_dump_state_e;

  localparam logic [7:0] PERF_DUMP_MAGIC = 8'hA5;

  localparam int PERF_NUM_COUNTERS  = 7;
  localparam int PERF_COUNTER_WIDTH = 32;
  localparam int PERF_OUT_WIDTH     = 16;

  function automatic int perf_dump_beats(input int n, input int cw, input int ow);
    return (n * cw) / ow;
  endfunction

  // Never return zero so a single-beat configuration still has an index register.
  function automatic int perf_idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int PERF_DUMP_BEATS =
    perf_dump_beats(PERF_NUM_COUNTERS, PERF_COUNTER_WIDTH, PERF_OUT_WIDTH);

  typedef logic [perf_idx_width(PERF_DUMP_BEATS)-1:0] perf_dump_beat_idx_t;

endpackage

// File: rtl/perf_counter_dump_controller_cell.sv
// One saturating event counter; clear has priority over a same-cycle increment.
module perf_counter_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             en,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/perf_counter_dump_controller.sv
// Live performance counters plus a snapshot that is streamed as a header beat
// followed by OUT_WIDTH-wide data beats over a valid/ready port.
//   state            | meaning
//   PERF_DUMP_IDLE   | no dump; dumpReq captures the snapshot
//   PERF_DUMP_HEADER | presenting {magic, counter count}
//   PERF_DUMP_DATA   | presenting snapshot word beat_idx
module perf_counter_dump_controller
  import perf_counter_dump_controller_pkg::*;
#(
  parameter int NUM_COUNTERS  = PERF_NUM_COUNTERS,
  parameter int COUNTER_WIDTH = PERF_COUNTER_WIDTH,
  parameter int OUT_WIDTH     = PERF_OUT_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rstN,
  input  logic                                  countEn,
  input  logic [NUM_COUNTERS-1:0]               eventInc,
  input  logic                                  clearReq,
  input  logic                                  dumpReq,
  output logic [OUT_WIDTH-1:0]                  dumpData,
  output logic                                  dumpValid,
  output logic                                  dumpLast,
  input  logic                                  dumpReady,
  output logic                                  busy,
  output logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] liveCount
);

  localparam int BEATS = perf_dump_beats(NUM_COUNTERS, COUNTER_WIDTH, OUT_WIDTH);
  localparam int IDX_W = perf_idx_width(BEATS);
  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(BEATS - 1);
  localparam logic [OUT_WIDTH-1:0] HEADER_WORD =
    {PERF_DUMP_MAGIC, (OUT_WIDTH-8)'(NUM_COUNTERS)};

  perf_dump_state_e               state, state_nxt;
  logic [IDX_W-1:0]               beat_idx;
  // Word 0 is counter 0's least-significant chunk, matching the beat order.
  logic [BEATS-1:0][OUT_WIDTH-1:0] snap;

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cell
    perf_counter_cell #(.WIDTH(COUNTER_WIDTH)) u_cell (
      .clk   (clk),
      .rstN  (rstN),
      .en    (countEn),
      .inc   (eventInc[i]),
      .clear (clearReq),
      .count (liveCount[i*COUNTER_WIDTH +: COUNTER_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state    <= PERF_DUMP_IDLE;
      beat_idx <= '0;
      snap     <= '0;
    end else begin
      state <= state_nxt;
      if (state == PERF_DUMP_IDLE && dumpReq) begin
        snap <= liveCount;
      end
      if (state == PERF_DUMP_HEADER) begin
        beat_idx <= '0;
      end else if (state == PERF_DUMP_DATA && dumpReady) begin
        beat_idx <= beat_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    dumpValid = 1'b0;
    dumpLast  = 1'b0;
    dumpData  = '0;
    case (state)
      PERF_DUMP_IDLE: begin
        if (dumpReq) state_nxt = PERF_DUMP_HEADER;
      end
      PERF_DUMP_HEADER: begin
        dumpValid = 1'b1;
        dumpData  = HEADER_WORD;
        if (dumpReady) state_nxt = PERF_DUMP_DATA;
      end
      PERF_DUMP_DATA: begin
        dumpValid = 1'b1;
        dumpData  = snap[beat_idx];
        dumpLast  = (beat_idx == LAST_IDX);
        if (dumpReady && dumpLast) state_nxt = PERF_DUMP_IDLE;
      end
      default: state_nxt = PERF_DUMP_IDLE;
    endcase
  end

  assign busy = (state != PERF_DUMP_IDLE);

endmodule

// File: tb/tb_perf_counter_dump_controller.sv
// Directed bench: default-sized controller plus a 16-bit-counter instance for saturation.
module tb_perf_counter_dump_controller;

  localparam int N     = 7;
  localparam int CW    = 32;
  localparam int OW    = 16;
  localparam int NBEAT = 15;

  typedef logic [31:0] cnt_arr_t [N];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstN, countEn, clearReq, dumpReq, dumpReady;
  logic [N-1:0]    eventInc;
  logic [OW-1:0]   dumpData;
  logic            dumpValid, dumpLast, busy;
  logic [N*CW-1:0] liveCount;

  logic            s_rstN, s_countEn, s_clearReq, s_dumpReq, s_dumpReady;
  logic [N-1:0]    s_eventInc;
  logic [15:0]     s_dumpData;
  logic            s_dumpValid, s_dumpLast, s_busy;
  logic [N*16-1:0] s_liveCount;

  perf_counter_dump_controller dut (
    .clk(clk), .rstN(rstN), .countEn(countEn), .eventInc(eventInc),
    .clearReq(clearReq), .dumpReq(dumpReq), .dumpData(dumpData),
    .dumpValid(dumpValid), .dumpLast(dumpLast), .dumpReady(dumpReady),
    .busy(busy), .liveCount(liveCount)
  );

  perf_counter_dump_controller #(.NUM_COUNTERS(7), .COUNTER_WIDTH(16), .OUT_WIDTH(16)) u_sat (
    .clk(clk), .rstN(s_rstN), .countEn(s_countEn), .eventInc(s_eventInc),
    .clearReq(s_clearReq), .dumpReq(s_dumpReq), .dumpData(s_dumpData),
    .dumpValid(s_dumpValid), .dumpLast(s_dumpLast), .dumpReady(s_dumpReady),
    .busy(s_busy), .liveCount(s_liveCount)
  );

  int total = 0;
  int bad   = 0;

  logic [OW-1:0] beats[$];
  logic [OW-1:0] cyc_data[$];
  bit            cyc_vld[$], cyc_rdy[$], cyc_last[$];
  int            nlast, ncyc;
  bit            timeout, aborted;

  function automatic logic [15:0] exp_word(input cnt_arr_t c, input int k);
    if (k == 0) return 16'hA507;
    return c[(k-1)/2][((k-1)%2)*16 +: 16];
  endfunction

  function automatic logic [N*CW-1:0] pack_live(input cnt_arr_t c);
    logic [N*CW-1:0] v;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = c[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump();
    dumpReq = 1'b1;
    step();
    dumpReq = 1'b0;
  endtask

  // Drives the sink side of one dump and records every cycle; beat numbers count the header as 0.
  task automatic collect(input bit rnd, input logic [N-1:0] ev,
                         input int clr_at, input int req_at, input int rst_at);
    bit got;
    int pres;
    beats.delete(); cyc_data.delete(); cyc_vld.delete(); cyc_rdy.delete(); cyc_last.delete();
    nlast = 0; ncyc = 0; timeout = 0; aborted = 0; got = 0;
    for (int c = 0; c < 400 && !got && !aborted; c++) begin
      pres      = beats.size();
      dumpReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      eventInc  = ev;
      clearReq  = (clr_at >= 0) && (pres == clr_at + 1);
      dumpReq   = (req_at >= 0) && (pres == req_at + 1);
      if (rst_at >= 0 && pres == rst_at + 1) begin
        rstN = 1'b0;
        step();
        aborted = 1;
      end else begin
        cyc_data.push_back(dumpData);
        cyc_vld.push_back(dumpValid);
        cyc_rdy.push_back(dumpReady);
        cyc_last.push_back(dumpLast);
        if (dumpValid && dumpReady) begin
          beats.push_back(dumpData);
          if (dumpLast) begin
            nlast++;
            got = 1;
          end
        end
        step();
        ncyc++;
      end
    end
    eventInc = '0; clearReq = 1'b0; dumpReq = 1'b0; dumpReady = 1'b1; rstN = 1'b1;
    timeout = !got && !aborted;
  endtask

  task automatic test_reset();
    cnt_arr_t z = '{default: 32'd0};
    rstN = 1'b0; countEn = 1'b1; eventInc = '1; clearReq = 1'b1; dumpReq = 1'b1; dumpReady = 1'b1;
    step(); step();
    total++; if (dumpValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dumpValid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (dumpLast !== 1'b0 || dumpData !== '0) begin bad++; $display("FAIL reset_data: got last=%b data=%h want 0/0000", dumpLast, dumpData); end
    total++; if (liveCount !== '0) begin bad++; $display("FAIL reset_live: got %h want 0", liveCount); end
    rstN = 1'b1; eventInc = '0; clearReq = 1'b0; dumpReq = 1'b0;
    start_dump();
    collect(0, '0, -1, -1, -1);
    total++; if (timeout || beats.size() != NBEAT) begin bad++; $display("FAIL reset_dump_len: got %0d want %0d", beats.size(), NBEAT); end
    for (int k = 0; k < beats.size() && k < NBEAT; k++) begin
      total++; if (beats[k] !== exp_word(z, k)) begin bad++; $display("FAIL reset_dump_beat%0d: got %h want %h", k, beats[k], exp_word(z, k)); end
    end
  endtask

  task automatic test_basic_dump();
    cnt_arr_t c = '{default: 32'd0};
    c[2] = 32'd5;
    eventInc = 7'b0000100;
    repeat (5) step();
    eventInc = '0;
    total++; if (liveCount !== pack_live(c)) begin bad++; $display("FAIL basic_live: got %h want %h", liveCount, pack_live(c)); end
    start_dump();
    collect(0, '0, -1, -1, -1);
    total++; if (timeout || beats.size() != NBEAT) begin bad++; $display("FAIL basic_len: got %0d want %0d", beats.size(), NBEAT); end
    for (int k = 0; k < beats.size() && k < NBEAT; k++) begin
      total++; if (beats[k] !== exp_word(c, k)) begin bad++; $display("FAIL basic_beat%0d: got %h want %h", k, beats[k], exp_word(c, k)); end
    end
    total++; if (ncyc != NBEAT) begin bad++; $display("FAIL basic_cycles: got %0d want %0d", ncyc, NBEAT); end
    for (int k = 0; k < cyc_last.size(); k++) begin
      total++; if (cyc_last[k] !== (k == NBEAT - 1)) begin bad++; $display("FAIL basic_last%0d: got %b want %b", k, cyc_last[k], k == NBEAT - 1); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_count_en();
    cnt_arr_t c = '{default: 32'd0};
    c[2] = 32'd5;
    countEn = 1'b0; eventInc = '1;
    repeat (3) step();
    total++; if (liveCount !== pack_live(c)) begin bad++; $display("FAIL hold_live: got %h want %h", liveCount, pack_live(c)); end
    countEn = 1'b1; eventInc = 7'b1010101;
    repeat (2) step();
    eventInc = '0;
    c[0] = 2; c[2] = 7; c[4] = 2; c[6] = 2;
    total++; if (liveCount !== pack_live(c)) begin bad++; $display("FAIL multi_live: got %h want %h", liveCount, pack_live(c)); end
  endtask

  task automatic test_backpressure();
    cnt_arr_t c;
    rstN = 1'b0; step(); rstN = 1'b1;
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) eventInc[i] = (i >= j);
      step();
    end
    for (int i = 0; i < N; i++) c[i] = 32'(i + 1);
    eventInc = '1;
    start_dump();
    collect(1, '1, -1, -1, -1);
    total++; if (timeout || beats.size() != NBEAT) begin bad++; $display("FAIL bp_len: got %0d want %0d", beats.size(), NBEAT); end
    for (int k = 0; k < beats.size() && k < NBEAT; k++) begin
      total++; if (beats[k] !== exp_word(c, k)) begin bad++; $display("FAIL bp_beat%0d: got %h want %h", k, beats[k], exp_word(c, k)); end
    end
    for (int k = 0; k + 1 < cyc_data.size(); k++) begin
      if (cyc_vld[k] && !cyc_rdy[k]) begin
        total++; if (cyc_data[k+1] !== cyc_data[k] || cyc_last[k+1] !== cyc_last[k]) begin
          bad++; $display("FAIL bp_stall%0d: got %h/%b want %h/%b", k, cyc_data[k+1], cyc_last[k+1], cyc_data[k], cyc_last[k]);
        end
      end
    end
    for (int i = 0; i < N; i++) c[i] = 32'(i + 2 + ncyc);
    total++; if (liveCount !== pack_live(c)) begin bad++; $display("FAIL bp_live_after: got %h want %h", liveCount, pack_live(c)); end
  endtask

  task automatic test_clear();
    cnt_arr_t c = '{default: 32'd0};
    clearReq = 1'b1; eventInc = 7'b0000010;
    step();
    clearReq = 1'b0; eventInc = '0;
    total++; if (liveCount !== '0) begin bad++; $display("FAIL clear_live: got %h want 0", liveCount); end
    eventInc = 7'b0001000;
    repeat (3) step();
    eventInc = '0;
    c[3] = 3;
    start_dump();
    collect(0, '0, 3, -1, -1);
    total++; if (timeout || beats.size() != NBEAT) begin bad++; $display("FAIL clear_len: got %0d want %0d", beats.size(), NBEAT); end
    for (int k = 0; k < beats.size() && k < NBEAT; k++) begin
      total++; if (beats[k] !== exp_word(c, k)) begin bad++; $display("FAIL clear_beat%0d: got %h want %h", k, beats[k], exp_word(c, k)); end
    end
    total++; if (liveCount !== '0) begin bad++; $display("FAIL clear_live_after: got %h want 0", liveCount); end
  endtask

  task automatic test_back_to_back();
    cnt_arr_t c = '{default: 32'd0};
    c[0] = 2;
    eventInc = 7'b0000001;
    repeat (2) step();
    eventInc = '0;
    start_dump();
    collect(0, '0, -1, 2, -1);
    total++; if (timeout || beats.size() != NBEAT || nlast != 1) begin bad++; $display("FAIL ignore_len: got %0d/%0d want %0d/1", beats.size(), nlast, NBEAT); end
    for (int k = 0; k < beats.size() && k < NBEAT; k++) begin
      total++; if (beats[k] !== exp_word(c, k)) begin bad++; $display("FAIL ignore_beat%0d: got %h want %h", k, beats[k], exp_word(c, k)); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", busy); end
    start_dump();
    collect(0, '0, -1, -1, -1);
    total++; if (timeout || beats.size() != NBEAT) begin bad++; $display("FAIL b2b_len: got %0d want %0d", beats.size(), NBEAT); end
    for (int k = 0; k < beats.size() && k < NBEAT; k++) begin
      total++; if (beats[k] !== exp_word(c, k)) begin bad++; $display("FAIL b2b_beat%0d: got %h want %h", k, beats[k], exp_word(c, k)); end
    end
  endtask

  task automatic test_abort();
    cnt_arr_t c = '{default: 32'd0};
    eventInc = 7'b0000010;
    step();
    eventInc = '0;
    start_dump();
    collect(0, '0, -1, -1, 4);
    total++; if (!aborted || nlast != 0) begin bad++; $display("FAIL abort_seen: got aborted=%b last=%0d want 1/0", aborted, nlast); end
    total++; if (dumpValid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b/%b want 0/0", dumpValid, busy); end
    total++; if (liveCount !== '0) begin bad++; $display("FAIL abort_live: got %h want 0", liveCount); end
    eventInc = 7'b1000000;
    step();
    eventInc = '0;
    c[6] = 1;
    start_dump();
    collect(0, '0, -1, -1, -1);
    total++; if (timeout || beats.size() != NBEAT) begin bad++; $display("FAIL abort_redump_len: got %0d want %0d", beats.size(), NBEAT); end
    for (int k = 0; k < beats.size() && k < NBEAT; k++) begin
      total++; if (beats[k] !== exp_word(c, k)) begin bad++; $display("FAIL abort_redump_beat%0d: got %h want %h", k, beats[k], exp_word(c, k)); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] sb[$];
    logic [15:0] exp_s [8] = '{16'hA507, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    bit done = 0;
    s_rstN = 1'b0; step(); s_rstN = 1'b1;
    s_countEn = 1'b1; s_eventInc = 7'b0000001;
    repeat (65534) step();
    total++; if (s_liveCount[15:0] !== 16'hFFFE) begin bad++; $display("FAIL sat_pre: got %h want fffe", s_liveCount[15:0]); end
    repeat (3) step();
    s_eventInc = '0;
    total++; if (s_liveCount !== {{6{16'h0}}, 16'hFFFF}) begin bad++; $display("FAIL sat_live: got %h want ffff in counter 0", s_liveCount); end
    s_dumpReq = 1'b1; step(); s_dumpReq = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      if (s_dumpValid && s_dumpReady) begin
        sb.push_back(s_dumpData);
        if (s_dumpLast) done = 1;
      end
      step();
    end
    total++; if (!done || sb.size() != 8) begin bad++; $display("FAIL sat_len: got %0d want 8", sb.size()); end
    for (int k = 0; k < sb.size() && k < 8; k++) begin
      total++; if (sb[k] !== exp_s[k]) begin bad++; $display("FAIL sat_beat%0d: got %h want %h", k, sb[k], exp_s[k]); end
    end
  endtask

  initial begin
    rstN = 1'b0; countEn = 1'b0; eventInc = '0; clearReq = 1'b0; dumpReq = 1'b0; dumpReady = 1'b1;
    s_rstN = 1'b0; s_countEn = 1'b0; s_eventInc = '0; s_clearReq = 1'b0; s_dumpReq = 1'b0; s_dumpReady = 1'b1;
    #1;
    test_reset();
    test_basic_dump();
    test_count_en();
    test_backpressure();
    test_clear();
    test_back_to_back();
    test_abort();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
